dmem_arbiter: RTL and testbench

- Shares the single data memory between two requesters: port 0 (pipeline memory-access stage) and port 1 (UART/loader path).
- Round-robin arbiter plus access sequencer: latches one request, issues it to memory for one cycle, waits the fixed read latency, then returns an ack and, for reads, the data.
- Sits between the memory-access stage and the data memory, replacing direct stage-to-memory wiring.

---
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the shared data memory.
// One access at a time: grant, one-cycle ISSUE, fixed read wait, then a one-cycle ack.
module dmem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ack,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  logic [1:0]            state;
  logic                  last_grant;
  logic                  gnt_id;
  logic                  lat_we;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] p0_rdata_q;
  logic [DATA_WIDTH-1:0] p1_rdata_q;
  logic                  pick1;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    pick1 = p1_req & (~p0_req | ~last_grant);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      lat_we     <= 1'b0;
      wait_cnt   <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (p0_req || p1_req) begin
            gnt_id     <= pick1;
            last_grant <= pick1;
            lat_we     <= pick1 ? p1_we    : p0_we;
            addr_q     <= pick1 ? p1_addr  : p0_addr;
            wdata_q    <= pick1 ? p1_wdata : p0_wdata;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (lat_we) begin
            state <= S_DONE;
          end else begin
            wait_cnt <= LAT_M1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            if (gnt_id) p1_rdata_q <= mem_rdata;
            else        p0_rdata_q <= mem_rdata;
            state <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_en    = (state == S_ISSUE);
    mem_we    = mem_en & lat_we;
    mem_re    = mem_en & ~lat_we;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    p0_ack    = (state == S_DONE) & ~gnt_id;
    p1_ack    = (state == S_DONE) & gnt_id;
    p0_rdata  = p0_rdata_q;
    p1_rdata  = p1_rdata_q;
    busy      = (state != S_IDLE);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance 0 (latency 2) is fully checked via a scoreboard,
// instances 1 and 2 (latency 1 and 5) share its inputs and are checked for read timing.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        CLK;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;

  logic [2:0]  p0_ack, p1_ack, mem_en, mem_we, mem_re, busy;
  logic [31:0] p0_rdata [3];
  logic [31:0] p1_rdata [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];

  int checks = 0;
  int failures = 0;
  logic [33:0] exp_q[$];
  logic [31:0] sb_rd [2];
  logic [31:0] wr_mem [int];

  function automatic logic [31:0] init_word(input int idx);
    logic [7:0] b;
    b = idx[7:0];
    if (idx == 8) return 32'h12345678;
    return {b, b ^ 8'h5A, ~b, b + 8'd3};
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] addr);
    int idx;
    idx = int'(addr[9:2]);
    if (wr_mem.exists(idx)) return wr_mem[idx];
    return init_word(idx);
  endfunction

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 5;
    logic [31:0] store [0:255];
    logic [31:0] pipe [0:15];

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L)) u_dut (
      .CLK(CLK), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack[g]), .p0_rdata(p0_rdata[g]),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack[g]), .p1_rdata(p1_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_re(mem_re[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .busy(busy[g])
    );

    initial begin
      for (int i = 0; i < 256; i++) store[i] <= init_word(i);
      for (int i = 0; i < 16; i++) pipe[i] <= 32'h0;
    end

    // Memory model: read data appears L cycles after the ISSUE cycle, garbage otherwise.
    always @(posedge CLK) begin
      if (mem_en[g] && mem_we[g]) store[mem_addr[g][9:2]] <= mem_wdata[g];
      pipe[0] <= (mem_en[g] && mem_re[g]) ? store[mem_addr[g][9:2]] : $urandom;
      for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = pipe[L-1];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sb_push(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    if (we) begin
      wr_mem[int'(addr[9:2])] = wdata;
      exp_q.push_back({port, we, 32'h0});
    end else begin
      exp_q.push_back({port, we, gold_rd(addr)});
    end
  endtask

  task automatic set_port(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    if (port) begin
      p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end else begin
      p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end
  endtask

  task automatic drive(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    set_port(port, we, addr, wdata);
    sb_push(port, we, addr, wdata);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    step();
    step();
    reset = 1'b0;
    sb_rd[0] = 32'h0;
    sb_rd[1] = 32'h0;
  endtask

  // Runs n cycles from the current one (k=0), recording ack cycles and write strobes.
  task automatic run_cycles(input int n, input bit auto_drop, output int ack0_at,
                            output int ack1_at, output int n_ack0, output int n_ack1,
                            output int n_wr);
    logic a0, a1;
    ack0_at = -1; ack1_at = -1; n_ack0 = 0; n_ack1 = 0; n_wr = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      a0 = p0_ack[0];
      a1 = p1_ack[0];
      if (a0) begin n_ack0++; if (ack0_at < 0) ack0_at = k; end
      if (a1) begin n_ack1++; if (ack1_at < 0) ack1_at = k; end
      if (mem_en[0] && mem_we[0]) n_wr++;
      step();
      if (auto_drop && a0) p0_req = 1'b0;
      if (auto_drop && a1) p1_req = 1'b0;
    end
  endtask

  // Scoreboard: every ack of instance 0 pops one expected completion.
  always @(negedge CLK) begin : sb_mon
    logic [33:0] e;
    if (!reset && (p0_ack[0] || p1_ack[0])) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_ack", {p1_ack[0], p0_ack[0]}, 0);
      end else begin
        e = exp_q.pop_front();
        if (!e[32]) sb_rd[e[33]] = e[31:0];
        check_eq("sb_ack_port", {p1_ack[0], p0_ack[0]}, e[33] ? 2 : 1);
        check_eq("sb_p0_rdata", p0_rdata[0], sb_rd[0]);
        check_eq("sb_p1_rdata", p1_rdata[0], sb_rd[1]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, a1, n0, n1, nw;
    int b0, b1, m0, m1, mw;
    int first [3];
    logic [31:0] fdata [3];

    reset = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
    do_reset();

    // Reset state
    @(negedge CLK);
    check_eq("rst_ctrl", {p0_ack[0], p1_ack[0], mem_en[0], mem_we[0], mem_re[0], busy[0]}, 0);
    check_eq("rst_mem_addr", mem_addr[0], 0);
    check_eq("rst_mem_wdata", mem_wdata[0], 0);
    check_eq("rst_rdata", {p0_rdata[0], p1_rdata[0]}, 0);
    step();

    // Port 0 write alone
    drive(0, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge CLK);
    check_eq("w_k0_busy", busy[0], 0);
    @(negedge CLK);
    check_eq("w_k1_strobes", {mem_en[0], mem_we[0], mem_re[0]}, 3'b110);
    check_eq("w_k1_addr", mem_addr[0], 32'h10);
    check_eq("w_k1_wdata", mem_wdata[0], 32'hDEADBEEF);
    check_eq("w_k1_ack", p0_ack[0], 0);
    @(negedge CLK);
    check_eq("w_k2_ack", {p0_ack[0], p1_ack[0]}, 2'b10);
    step();
    p0_req = 1'b0;
    @(negedge CLK);
    check_eq("w_k3_ack_busy", {p0_ack[0], busy[0], mem_en[0]}, 0);
    check_eq("w_k3_addr_hold", mem_addr[0], 32'h10);
    step();

    // Port 1 read, data returned two cycles after ISSUE
    drive(1, 1'b0, 32'h20, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    check_eq("r_k1_strobes", {mem_en[0], mem_we[0], mem_re[0]}, 3'b101);
    check_eq("r_k1_addr", mem_addr[0], 32'h20);
    @(negedge CLK);
    check_eq("r_k2_wait", {mem_en[0], mem_re[0], p1_ack[0], busy[0]}, 4'b0001);
    @(negedge CLK);
    check_eq("r_k3_wait", {mem_en[0], mem_re[0], p1_ack[0], busy[0]}, 4'b0001);
    @(negedge CLK);
    check_eq("r_k4_ack", {p0_ack[0], p1_ack[0]}, 2'b01);
    check_eq("r_k4_rdata", p1_rdata[0], 32'h12345678);
    check_eq("r_k4_p0_rdata", p0_rdata[0], 32'h0);
    step();
    p1_req = 1'b0;
    step();

    // Simultaneous reads from reset: port 0 first, port 1 in the next IDLE
    do_reset();
    drive(0, 1'b0, 32'h30, 32'h0);
    drive(1, 1'b0, 32'h40, 32'h0);
    run_cycles(12, 1'b1, a0, a1, n0, n1, nw);
    check_eq("tie_ack0_at", a0, 4);
    check_eq("tie_ack1_at", a1, 9);
    check_eq("tie_counts", {n0[3:0], n1[3:0]}, 8'h11);

    // Both held: grants alternate 0,1,0,1
    set_port(0, 1'b0, 32'h40, 32'h0);
    set_port(1, 1'b0, 32'h30, 32'h0);
    for (int i = 0; i < 2; i++) begin
      sb_push(0, 1'b0, 32'h40, 32'h0);
      sb_push(1, 1'b0, 32'h30, 32'h0);
    end
    run_cycles(20, 1'b0, a0, a1, n0, n1, nw);
    p0_req = 1'b0;
    p1_req = 1'b0;
    check_eq("rr_first_acks", {a0[7:0], a1[7:0]}, {8'd4, 8'd9});
    check_eq("rr_counts", {n0[3:0], n1[3:0]}, 8'h22);

    // Port 0 write with req held one cycle past ack: two writes
    drive(0, 1'b1, 32'h50, 32'hA5A50001);
    sb_push(0, 1'b1, 32'h50, 32'hA5A50001);
    run_cycles(4, 1'b0, a0, a1, n0, n1, nw);
    p0_req = 1'b0;
    run_cycles(6, 1'b0, b0, b1, m0, m1, mw);
    check_eq("b2b_ack_at", {a0[7:0], b0[7:0]}, {8'd2, 8'd1});
    check_eq("b2b_writes", nw + mw, 2);
    check_eq("b2b_acks", n0 + m0, 2);

    // Drop on ack edge: exactly one write, then read it back through port 1
    drive(0, 1'b1, 32'h54, 32'hC0FFEE11);
    run_cycles(8, 1'b1, a0, a1, n0, n1, nw);
    check_eq("single_write", {nw[3:0], n0[3:0]}, 8'h11);
    check_eq("single_ack_at", a0, 2);
    drive(1, 1'b0, 32'h54, 32'h0);
    run_cycles(8, 1'b1, a0, a1, n0, n1, nw);
    check_eq("readback_ack_at", a1, 4);
    check_eq("readback_data", p1_rdata[0], 32'hC0FFEE11);

    // Reset during WAIT of a port 1 read: abandoned, no ack
    set_port(1, 1'b0, 32'h30, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    check_eq("abort_in_wait", {busy[0], mem_en[0]}, 2'b10);
    reset = 1'b1;
    p1_req = 1'b0;
    step();
    @(negedge CLK);
    check_eq("abort_ctrl", {p0_ack[0], p1_ack[0], mem_en[0], mem_we[0], mem_re[0], busy[0]}, 0);
    check_eq("abort_mem", {mem_addr[0], mem_wdata[0]}, 0);
    check_eq("abort_rdata", {p0_rdata[0], p1_rdata[0]}, 0);
    step();
    reset = 1'b0;
    sb_rd[0] = 32'h0;
    sb_rd[1] = 32'h0;
    run_cycles(4, 1'b1, a0, a1, n0, n1, nw);
    check_eq("abort_no_ack", n0 + n1, 0);
    drive(0, 1'b0, 32'h40, 32'h0);
    drive(1, 1'b0, 32'h30, 32'h0);
    run_cycles(12, 1'b1, a0, a1, n0, n1, nw);
    check_eq("abort_tie_order", {a0[7:0], a1[7:0]}, {8'd4, 8'd9});

    // Read latency across builds (1, 2, 5), req held until the slowest acks
    do_reset();
    drive(1, 1'b0, 32'h20, 32'h0);
    sb_push(1, 1'b0, 32'h20, 32'h0);
    for (int g = 0; g < 3; g++) begin first[g] = -1; fdata[g] = 32'h0; end
    for (int k = 0; k < 14; k++) begin
      logic drop_now;
      @(negedge CLK);
      drop_now = 1'b0;
      for (int g = 0; g < 3; g++) begin
        if (p1_ack[g] && first[g] < 0) begin
          first[g] = k;
          fdata[g] = p1_rdata[g];
          if (g == 2) drop_now = 1'b1;
        end
      end
      step();
      if (drop_now) p1_req = 1'b0;
    end
    p1_req = 1'b0;
    check_eq("lat2_ack_at", first[0], 4);
    check_eq("lat1_ack_at", first[1], 3);
    check_eq("lat5_ack_at", first[2], 7);
    check_eq("lat1_data", fdata[1], 32'h12345678);
    check_eq("lat5_data", fdata[2], 32'h12345678);

    repeat (8) step();
    check_eq("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
